// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, truncating
// quotient, remainder takes the dividend's sign. One restoring step per clock.
module seq_signed_div #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(2*WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] q;
    logic [WIDTH-1:0]   pr;
    logic [WIDTH-1:0]   dv_mag;
    logic [WIDTH-1:0]   dd_lo;
    logic [CW-1:0]      cnt;
    logic               sign_q;
    logic               sign_r;
    logic               dbz;
    logic               ovf;

    logic [2*WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0]   dv_abs;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   pr_sub;
    logic [2*WIDTH-1:0] q_fix;
    logic [WIDTH-1:0]   pr_fix;
    logic               ovf_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The unsigned pattern of the negated most-negative value is exactly its magnitude.
    always_comb begin
        dd_abs  = dividend[2*WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dv_abs  = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
        trial   = {pr, q[2*WIDTH-1]};
        ge      = (trial >= {1'b0, dv_mag});
        pr_sub  = trial[WIDTH-1:0] - dv_mag;
        q_fix   = sign_q ? (~q + 1'b1) : q;
        pr_fix  = sign_r ? (~pr + 1'b1) : pr;
        ovf_fix = !((&q_fix[2*WIDTH-1:WIDTH-1]) || !(|q_fix[2*WIDTH-1:WIDTH-1]));
    end

    // Outputs are registered off the state, so done appears the cycle after DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            q           <= '0;
            pr          <= '0;
            dv_mag      <= '0;
            dd_lo       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= (state == DONE);
            busy <= ((state == IDLE) && start) || (state == CALC) || (state == FIXUP);
            case (state)
                IDLE: begin
                    if (start) begin
                        q      <= dd_abs;
                        pr     <= '0;
                        dv_mag <= dv_abs;
                        dd_lo  <= dividend[WIDTH-1:0];
                        sign_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[2*WIDTH-1];
                        dbz    <= (divisor == '0);
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (ge) begin
                        pr <= pr_sub;
                        q  <= {q[2*WIDTH-2:0], 1'b1};
                    end else begin
                        pr <= trial[WIDTH-1:0];
                        q  <= {q[2*WIDTH-2:0], 1'b0};
                    end
                end
                FIXUP: begin
                    q   <= q_fix;
                    pr  <= pr_fix;
                    ovf <= ovf_fix;
                end
                DONE: begin
                    quot        <= dbz ? '1 : q[WIDTH-1:0];
                    rem         <= dbz ? dd_lo : pr;
                    div_by_zero <= dbz;
                    overflow    <= !dbz && ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_div.sv
// Directed bench for seq_signed_div: signed round trips, boundaries, divide-by-zero,
// handshake and mid-operation reset.
module tb_seq_signed_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    seq_signed_div #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and return the edge index (after start) at which done is seen.
    task automatic apply_stimulus(input logic [31:0] dd, input logic [15:0] dv, output int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input logic [15:0] eq,
                                input logic [15:0] er, input logic edbz, input logic eovf);
        check_output({tag, ".latency"}, lat, 34);
        check_output({tag, ".quot"}, quot, eq);
        check_output({tag, ".rem"}, rem, er);
        check_output({tag, ".dbz"}, div_by_zero, edbz);
        check_output({tag, ".ovf"}, overflow, eovf);
        check_output({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int n;
        int first;
        int second;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset.busy", busy, 1'b0);
        check_output("reset.done", done, 1'b0);
        check_output("reset.quot", quot, 16'h0000);
        check_output("reset.rem", rem, 16'h0000);
        check_output("reset.dbz", div_by_zero, 1'b0);
        check_output("reset.ovf", overflow, 1'b0);
        rst_n = 1'b1;

        $display("[TB] signed round trips");
        apply_stimulus(32'hFFFF_FD8F, 16'h0019, lat);
        check_result("m625_by_25", lat, 16'hFFE7, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(32'hFFFF_FFDA, 16'hFFFE, lat);
        check_result("m38_by_m2", lat, 16'h0013, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(32'h0000_01DB, 16'hFFE7, lat);
        check_result("475_by_m25", lat, 16'hFFED, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(32'h0000_01DD, 16'hFFE7, lat);
        check_result("477_by_m25", lat, 16'hFFED, 16'h0002, 1'b0, 1'b0);
        apply_stimulus(32'hFFFF_FE23, 16'h0019, lat);
        check_result("m477_by_25", lat, 16'hFFED, 16'hFFFE, 1'b0, 1'b0);

        $display("[TB] boundaries");
        apply_stimulus(32'h4000_0000, 16'h8000, lat);
        check_result("2p30_by_minneg", lat, 16'h8000, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(32'h4000_0000, 16'h0001, lat);
        check_result("2p30_by_1", lat, 16'h0000, 16'h0000, 1'b0, 1'b1);
        apply_stimulus(32'h8000_0000, 16'hFFFF, lat);
        check_result("minneg_by_m1", lat, 16'h0000, 16'h0000, 1'b0, 1'b1);

        $display("[TB] divide by zero");
        apply_stimulus(32'hFFFF_FD8F, 16'h0000, lat);
        check_result("dbz", lat, 16'hFFFF, 16'hFD8F, 1'b1, 1'b0);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        dividend = 32'h0000_0064;
        divisor  = 16'h0007;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("midrst.busy", busy, 1'b0);
        check_output("midrst.done", done, 1'b0);
        check_output("midrst.quot", quot, 16'h0000);
        check_output("midrst.rem", rem, 16'h0000);
        check_output("midrst.dbz", div_by_zero, 1'b0);
        check_output("midrst.ovf", overflow, 1'b0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check_output("midrst.no_done", n, 0);
        apply_stimulus(32'h0000_01DD, 16'hFFE7, lat);
        check_result("after_rst", lat, 16'hFFED, 16'h0002, 1'b0, 1'b0);

        $display("[TB] start while busy");
        @(negedge clk);
        dividend = 32'h0000_01DD;
        divisor  = 16'hFFE7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n++;
                if (first < 0) first = k;
            end
            if (k == 5) check_output("busy_mid", busy, 1'b1);
            start = (k == 5 || k == 33);
            if (k == 5 || k == 33) begin
                dividend = 32'h0000_0064;
                divisor  = 16'h0007;
            end
        end
        check_output("ignore.first_done", first, 34);
        check_output("ignore.done_count", n, 1);
        check_output("ignore.quot", quot, 16'hFFED);
        check_output("ignore.rem", rem, 16'h0002);

        $display("[TB] start held high");
        @(negedge clk);
        dividend = 32'h0000_0064;
        divisor  = 16'h0007;
        start    = 1'b1;
        @(posedge clk);
        n      = 0;
        first  = -1;
        second = -1;
        for (int k = 1; k <= 69; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 69) start = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check_output("held.first_done", first, 34);
        check_output("held.second_done", second, 69);
        check_output("held.done_count", n, 2);
        check_output("held.quot", quot, 16'h000E);
        check_output("held.rem", rem, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
